sram_pipe_2p: RTL and testbench

//   Parametrised simple-dual-port SRAM: one write port, one read port, per-lane write mask.

---
 rtl/sram_pipe_2p_if.sv | 41 ++++
 rtl/sram_pipe_2p.sv | 182 ++++++++++++++++++
 tb/tb_sram_pipe_2p.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pipe_2p_if.sv
// Bus bundle for sram_pipe_2p: write port, read port, clear request and status.
// Optional parity signals are present only when SRAM_PARITY_EN is defined.
interface sram_pipe_2p_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 1
);
   logic                  chip_en;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] din;
   logic [LANES-1:0]      wmask;
   logic                  ren;
   logic [ADDR_WIDTH-1:0] raddr;
   logic                  clr;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  init_busy;
`ifdef SRAM_PARITY_EN
   logic                  par_inj;
   logic                  parity_err;
`endif

   modport master (
      output chip_en, wen, waddr, din, wmask, ren, raddr, clr,
      input  dout, dout_valid, init_busy
`ifdef SRAM_PARITY_EN
      , output par_inj
      , input  parity_err
`endif
   );

   modport slave (
      input  chip_en, wen, waddr, din, wmask, ren, raddr, clr,
      output dout, dout_valid, init_busy
`ifdef SRAM_PARITY_EN
      , input  par_inj
      , output parity_err
`endif
   );
endinterface

// File: rtl/sram_pipe_2p.sv
// Simple dual-port SRAM buffer with lane write mask, pipelined read (RD_LAT clocks)
// and a self-clearing init sequencer in place of an array reset.
// Optional macro SRAM_PARITY_EN adds one even-parity bit per word, a write-side
// parity inject (par_inj) and a read-side parity_err flag aligned with dout_valid.
//
// state    | meaning
// ST_CLEAR | sequencer writes zero to address cnt each cycle; user accesses dropped
// ST_IDLE  | array ready; user reads and writes accepted when chip_en is high
module sram_pipe_2p #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 16,
   parameter int LANE_W     = 8,
   parameter int RD_LAT     = 1
) (
   input  logic         clk,
   input  logic         rst,
   sram_pipe_2p_if.slave bus
);
   localparam int LANES = DATA_WIDTH / LANE_W;
   localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  user_ok;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_en;
   logic                  rd_en;
   logic                  clr_wr;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] pipe_dat [RD_LAT];
   logic [RD_LAT-1:0]     pipe_vld;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  dout_valid_q;

`ifdef SRAM_PARITY_EN
   logic                  mem_par [MEM_DEPTH];
   logic                  wr_par;
   logic                  rd_err;
   logic [RD_LAT-1:0]     pipe_err;
   logic                  parity_err_q;
`endif

   assign user_ok     = (state_q == ST_IDLE) && bus.chip_en;
   assign wr_in_range = {1'b0, bus.waddr} < DEPTH_X;
   assign rd_in_range = {1'b0, bus.raddr} < DEPTH_X;
   // clr on an idle edge pre-empts a write but not a read
   assign wr_en       = user_ok && bus.wen && !bus.clr && (|bus.wmask) && wr_in_range;
   assign rd_en       = user_ok && bus.ren;
   assign clr_wr      = (state_q == ST_CLEAR);

   // state register for the clear sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // next-state: walk the array once, restart whenever clr is seen
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_CLEAR: begin
            if (bus.clr) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IDLE: begin
            if (bus.clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // merged write word: din on masked lanes, stored data elsewhere
   always_comb begin
      wr_word = mem[bus.waddr];
      for (int k = 0; k < LANES; k++) begin
         if (bus.wmask[k]) wr_word[k*LANE_W +: LANE_W] = bus.din[k*LANE_W +: LANE_W];
      end
   end

   // read word with write-first bypass; out-of-range reads return zero
   always_comb begin
      if (!rd_in_range)                         rd_word = '0;
      else if (wr_en && bus.waddr == bus.raddr) rd_word = wr_word;
      else                                      rd_word = mem[bus.raddr];
   end

   // array write: sequencer zeroes have priority, no reset of the storage itself
   always_ff @(posedge clk) begin
      if (clr_wr)     mem[cnt_q]     <= '0;
      else if (wr_en) mem[bus.waddr] <= wr_word;
   end

   // read data pipe; data captured at the accept edge so later writes cannot alter it
   always_ff @(posedge clk) begin
      pipe_dat[0] <= rd_word;
      for (int k = 1; k < RD_LAT; k++) pipe_dat[k] <= pipe_dat[k-1];
   end

   // read valid pipe, keeps draining during a clear
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= rd_en;
         for (int k = 1; k < RD_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
      end
   end

   // output stage: dout holds its value between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_valid_q <= pipe_vld[RD_LAT-1];
         if (pipe_vld[RD_LAT-1]) dout_q <= pipe_dat[RD_LAT-1];
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.init_busy  = (state_q == ST_CLEAR);

`ifdef SRAM_PARITY_EN
   assign wr_par = (^wr_word) ^ bus.par_inj;

   // parity check of the word being read; bypassed reads see the parity being written
   always_comb begin
      if (!rd_in_range)                         rd_err = 1'b0;
      else if (wr_en && bus.waddr == bus.raddr) rd_err = (^rd_word) ^ wr_par;
      else                                      rd_err = (^rd_word) ^ mem_par[bus.raddr];
   end

   // parity storage follows the data array
   always_ff @(posedge clk) begin
      if (clr_wr)     mem_par[cnt_q]     <= 1'b0;
      else if (wr_en) mem_par[bus.waddr] <= wr_par;
   end

   // parity error travels with its read through the pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_err     <= '0;
         parity_err_q <= 1'b0;
      end else begin
         pipe_err[0] <= rd_err;
         for (int k = 1; k < RD_LAT; k++) pipe_err[k] <= pipe_err[k-1];
         parity_err_q <= pipe_vld[RD_LAT-1] & pipe_err[RD_LAT-1];
      end
   end

   assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_sram_pipe_2p.sv
// Directed bench for sram_pipe_2p (16-bit words, two 8-bit lanes, RD_LAT=2).
// Expected read results are queued with the edge they must appear on; every
// cycle the outputs are compared against that queue and against held dout.
module tb_sram_pipe_2p;
   localparam int AW     = 4;
   localparam int DW     = 16;
   localparam int DEPTH  = 16;
   localparam int LW     = 8;
   localparam int RD_LAT = 2;

   typedef struct {
      int          due;
      logic [15:0] d;
      logic        pe;
   } exp_t;

   logic        clk;
   logic        rst;
   int          cyc;
   int          n_assert;
   int          n_fail;
   bit          chk_en;
   logic [15:0] last_dout;
   exp_t        q[$];
   exp_t        e;
   int          n;

   sram_pipe_2p_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(2)) bus ();

   sram_pipe_2p #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .LANE_W(LW), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] wval(input int i);
      return {8'(8'hA0 + i), 8'(i)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rd_valid", {31'd0, bus.dout_valid}, 32'd1);
            chk("rd_data", {16'd0, bus.dout}, {16'd0, e.d});
`ifdef SRAM_PARITY_EN
            chk("par_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
`endif
            last_dout = e.d;
         end else begin
            chk("no_valid", {31'd0, bus.dout_valid}, 32'd0);
            chk("dout_hold", {16'd0, bus.dout}, {16'd0, last_dout});
`ifdef SRAM_PARITY_EN
            chk("par_idle", {31'd0, bus.parity_err}, 32'd0);
`endif
         end
      end
   endtask

   task automatic drive(input logic ce, input logic we, input logic [3:0] wa,
                        input logic [15:0] d, input logic [1:0] m,
                        input logic re, input logic [3:0] ra, input logic c);
      bus.chip_en = ce;
      bus.wen     = we;
      bus.waddr   = wa;
      bus.din     = d;
      bus.wmask   = m;
      bus.ren     = re;
      bus.raddr   = ra;
      bus.clr     = c;
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0, 1'b0);
   endtask

   // the read driven now is sampled at the next edge and appears RD_LAT edges later
   task automatic expect_rd(input logic [15:0] d, input logic pe);
      q.push_back('{cyc + 1 + RD_LAT, d, pe});
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < RD_LAT + 2; i++) tick();
   endtask

   initial begin
      cyc = 0; n_assert = 0; n_fail = 0; chk_en = 0; last_dout = '0;
      idle();
`ifdef SRAM_PARITY_EN
      bus.par_inj = 1'b0;
`endif
      // reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_dout", {16'd0, bus.dout}, 32'd0);
      chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.init_busy}, 32'd1);
`ifdef SRAM_PARITY_EN
      chk("rst_perr", {31'd0, bus.parity_err}, 32'd0);
`endif
      chk_en = 1;
      rst = 1'b0;

      // init clear lasts exactly DEPTH cycles
      n = 0;
      while (bus.init_busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("init_len", n, 32'd16);

      // whole array reads zero, back-to-back
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(i), 1'b0);
         expect_rd(16'h0000, 1'b0);
         tick();
      end
      drain();

      // write 0xA5 @3, read it next cycle
      drive(1'b1, 1'b1, 4'd3, 16'h00A5, 2'b11, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b0);
      expect_rd(16'h00A5, 1'b0);
      tick();
      drain();

      // lane-masked write with same-edge read: write-first on the masked lane only
      drive(1'b1, 1'b1, 4'd5, 16'h1234, 2'b11, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 4'd5, 16'hABCD, 2'b10, 1'b1, 4'd5, 1'b0);
      expect_rd(16'hAB34, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b0);
      expect_rd(16'hAB34, 1'b0);
      tick();
      // wmask=0 and chip_en=0 writes are no-ops; chip_en=0 read gives no strobe
      drive(1'b1, 1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 4'd5, 16'h1111, 2'b11, 1'b1, 4'd5, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b0);
      expect_rd(16'hAB34, 1'b0);
      tick();
      drain();

      // fill, then 16 back-to-back reads with no bubbles
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b1, 4'(i), wval(i), 2'b11, 1'b0, 4'd0, 1'b0);
         tick();
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(i), 1'b0);
         expect_rd(wval(i), 1'b0);
         tick();
      end
      drain();

      // a write after the read edge must not reach the in-flight read
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b0);
      expect_rd(16'hA303, 1'b0);
      tick();
      drive(1'b1, 1'b1, 4'd3, 16'hDEAD, 2'b11, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b0);
      expect_rd(16'hDEAD, 1'b0);
      tick();
      drain();

      // clr mid-traffic: in-flight reads drain, clr-edge write dropped, read accepted
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0);
      expect_rd(16'hA000, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd1, 1'b0);
      expect_rd(16'hA101, 1'b0);
      tick();
      drive(1'b1, 1'b1, 4'd2, 16'hBEEF, 2'b11, 1'b1, 4'd2, 1'b1);
      expect_rd(16'hA202, 1'b0);
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b1, 4'd7, 1'b0);
         tick();
         chk("clr_busy", {31'd0, bus.init_busy}, (i < DEPTH - 1) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(i), 1'b0);
         expect_rd(16'h0000, 1'b0);
         tick();
      end
      drain();

      // clr during a clear restarts the walk from address 0
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1);
      tick();
      idle();
      for (int i = 0; i < 5; i++) tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1);
      tick();
      idle();
      n = 0;
      while (bus.init_busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("restart_len", n, 32'd16);

`ifdef SRAM_PARITY_EN
      // injected parity is flagged; a clean rewrite clears it
      bus.par_inj = 1'b1;
      drive(1'b1, 1'b1, 4'd7, 16'h000F, 2'b11, 1'b0, 4'd0, 1'b0);
      tick();
      bus.par_inj = 1'b0;
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b0);
      expect_rd(16'h000F, 1'b1);
      tick();
      drive(1'b1, 1'b1, 4'd7, 16'h000F, 2'b11, 1'b1, 4'd7, 1'b0);
      expect_rd(16'h000F, 1'b0);
      tick();
      drive(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b0);
      expect_rd(16'h000F, 1'b0);
      tick();
      drain();
`endif

      chk("queue_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
